// File: rtl/fe_capture_sequencer_if.sv
// Control and status bundle between the capture sequencer, the register block and the fe_capture datapath.
// The slave side is the sequencer. The master side is the register/datapath environment that drives it.
interface fe_capture_sequencer_if #(
  parameter int pDELAY_WIDTH   = 20,
  parameter int pTRIGW_WIDTH   = 8,
  parameter int pTIMEOUT_WIDTH = 32
);
  logic                      I_arm;
  logic                      I_pattern_match;
  logic                      I_sw_trigger;
  logic [pDELAY_WIDTH-1:0]   I_delay;
  logic [pTRIGW_WIDTH-1:0]   I_trig_width;
  logic [pTIMEOUT_WIDTH-1:0] I_timeout;
  logic                      I_capturing;
  logic                      O_capture_enable;
  logic                      O_trig_out;
  logic                      O_armed;
  logic                      O_done;
  logic                      O_timed_out;
  logic [2:0]                O_state;

  modport master (
    output I_arm, I_pattern_match, I_sw_trigger, I_delay, I_trig_width, I_timeout, I_capturing,
    input  O_capture_enable, O_trig_out, O_armed, O_done, O_timed_out, O_state
  );

  modport slave (
    input  I_arm, I_pattern_match, I_sw_trigger, I_delay, I_trig_width, I_timeout, I_capturing,
    output O_capture_enable, O_trig_out, O_armed, O_done, O_timed_out, O_state
  );
endinterface

// File: rtl/fe_capture_sequencer.sv
// Front-end capture run sequencer: arm -> trigger -> delay -> capture -> done, plus a trigger-out pulse.
// Optional armed timeout is compiled in when FE_CAPTURE_SEQ_TIMEOUT_EN is defined.
module fe_capture_sequencer #(
  parameter int pDELAY_WIDTH   = 20,
  parameter int pTRIGW_WIDTH   = 8,
  parameter int pTIMEOUT_WIDTH = 32
) (
  input  logic                  fe_clk,
  input  logic                  reset_i,
  fe_capture_sequencer_if.slave sif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e                  state, state_nxt;
  logic                    arm_s1, arm_r, arm_r_d, arm_rise;
  logic                    trig, trig_acc, cap_seen, to_hit;
  logic [pDELAY_WIDTH-1:0] delay_ctr;
  logic [pTRIGW_WIDTH-1:0] trigw_ctr;

  assign arm_rise = arm_r & ~arm_r_d;
  assign trig     = sif.I_pattern_match | sif.I_sw_trigger;
  // Arm loss in the same cycle beats the trigger, so no pulse or delay load either.
  assign trig_acc = (state == S_ARMED) & arm_r & trig;

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state    <= S_IDLE;
      arm_s1   <= 1'b0;
      arm_r    <= 1'b0;
      arm_r_d  <= 1'b0;
      cap_seen <= 1'b0;
    end else begin
      state    <= state_nxt;
      arm_s1   <= sif.I_arm;
      arm_r    <= arm_s1;
      arm_r_d  <= arm_r;
      // High from the second CAPTURE cycle on; the datapath status lags enable by one cycle.
      cap_seen <= (state == S_CAPTURE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (arm_rise) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (!arm_r)                   state_nxt = S_IDLE;
        else if (trig)                state_nxt = (sif.I_delay == '0) ? S_CAPTURE : S_DELAY;
        else if (to_hit)              state_nxt = S_DONE;
      end
      S_DELAY: begin
        if (!arm_r)                   state_nxt = S_IDLE;
        else if (delay_ctr == sif.I_delay) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!arm_r)                   state_nxt = S_IDLE;
        else if (cap_seen && !sif.I_capturing) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!arm_r)                   state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sif.O_capture_enable = (state == S_CAPTURE);
    sif.O_armed          = (state == S_ARMED) || (state == S_DELAY);
    sif.O_done           = (state == S_DONE);
    sif.O_state          = state;
  end

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      delay_ctr <= '0;
      trigw_ctr <= '0;
    end else begin
      // Saturates so an all-ones delay still matches instead of wrapping past it.
      if (trig_acc)
        delay_ctr <= pDELAY_WIDTH'(1);
      else if ((state == S_DELAY) && (delay_ctr != '1))
        delay_ctr <= delay_ctr + pDELAY_WIDTH'(1);

      // Pulse is independent of state once launched; only reset cuts it short.
      if (trig_acc)
        trigw_ctr <= sif.I_trig_width;
      else if (trigw_ctr != '0)
        trigw_ctr <= trigw_ctr - pTRIGW_WIDTH'(1);
    end
  end

  assign sif.O_trig_out = (trigw_ctr != '0) & ~reset_i;

`ifdef FE_CAPTURE_SEQ_TIMEOUT_EN
  logic [pTIMEOUT_WIDTH-1:0] to_ctr;
  logic                      timed_out;

  assign to_hit = (state == S_ARMED) & arm_r & ~trig & (sif.I_timeout != '0) &
                  (to_ctr == (sif.I_timeout - pTIMEOUT_WIDTH'(1)));

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      to_ctr    <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == S_IDLE)
        to_ctr <= '0;
      else if ((state == S_ARMED) && (to_ctr != '1))
        to_ctr <= to_ctr + pTIMEOUT_WIDTH'(1);

      if ((state == S_IDLE) && arm_rise)
        timed_out <= 1'b0;
      else if (to_hit)
        timed_out <= 1'b1;
    end
  end

  assign sif.O_timed_out = timed_out;
`else
  logic [pTIMEOUT_WIDTH-1:0] unused_timeout;

  assign unused_timeout  = sif.I_timeout;
  assign to_hit          = 1'b0;
  assign sif.O_timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_fe_capture_sequencer.sv
// Randomized run-level bench for fe_capture_sequencer: expected per-cycle outputs come from run timelines.
// Covers the timeout feature too when FE_CAPTURE_SEQ_TIMEOUT_EN is defined.
module tb_fe_capture_sequencer;
  localparam int DW  = 6;
  localparam int TW  = 4;
  localparam int TOW = 12;
`ifdef FE_CAPTURE_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic fe_clk  = 1'b0;
  logic reset_i = 1'b1;
  always #5 fe_clk = ~fe_clk;

  fe_capture_sequencer_if #(.pDELAY_WIDTH(DW), .pTRIGW_WIDTH(TW), .pTIMEOUT_WIDTH(TOW)) bus ();

  fe_capture_sequencer #(.pDELAY_WIDTH(DW), .pTRIGW_WIDTH(TW), .pTIMEOUT_WIDTH(TOW)) dut (
    .fe_clk  (fe_clk),
    .reset_i (reset_i),
    .sif     (bus)
  );

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       cap, trig, armed, done, tmo;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  bit   prev_tmo = 1'b0;
  bit   finishing = 1'b0, drained = 1'b0;

  // Timeline of the current run, in absolute cycles.
  int m_s, m_n, m_c, m_e, m_tt, m_a, m_rs, m_w;
  bit m_acc, m_hit, m_ptmo;

  always @(posedge fe_clk) cyc <= cyc + 1;

  // Monitor: every cycle pops whatever is due and compares the whole output set.
  always @(negedge fe_clk) begin
    exp_t       e;
    logic [7:0] act, req;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = {bus.O_state, bus.O_capture_enable, bus.O_trig_out, bus.O_armed, bus.O_done, bus.O_timed_out};
      req = {e.st, e.cap, e.trig, e.armed, e.done, e.tmo};
      n_chk++;
      if (e.cyc == cyc && act === req) n_pass++;
      else $display("FAIL outputs cyc=%0d (exp for %0d): got st=%0d cap=%b trig=%b armed=%b done=%b tmo=%b, want st=%0d cap=%b trig=%b armed=%b done=%b tmo=%b",
                    cyc, e.cyc, act[7:5], act[4], act[3], act[2], act[1], act[0],
                    req[7:5], req[4], req[3], req[2], req[1], req[0]);
    end
    if (finishing && !drained) begin
      n_chk++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      drained = 1'b1;
    end
  end

  function automatic exp_t model_at(input int t);
    exp_t x;
    int   st;
    st = 0;
    if (t >= m_s + 3 && t <= m_a) begin
      if (m_hit)                  st = (t <= m_tt) ? 1 : 4;
      else if (!m_acc || t <= m_n) st = 1;
      else if (t < m_c)           st = 2;
      else if (t <= m_e)          st = 3;
      else                        st = 4;
    end
    if (m_rs >= 0 && t > m_rs) st = 0;
    x.cyc   = t;
    x.st    = 3'(st);
    x.cap   = (st == 3);
    x.armed = (st == 1) || (st == 2);
    x.done  = (st == 4);
    x.trig  = m_acc && t > m_n && t <= m_n + m_w && !(m_rs >= 0 && t >= m_rs);
    x.tmo   = (t < m_s + 3) ? m_ptmo : (m_hit && t > m_tt);
    if (m_rs >= 0 && t > m_rs) x.tmo = 1'b0;
    return x;
  endfunction

  // One arm..disarm run. abort: 0 none, 1 random arm loss, 2 arm loss on the trigger cycle.
  // rst_off >= 0 pulses reset_i rst_off+1 cycles after the trigger.
  task automatic do_run(input int d, w, l, p, kind, abort, q, to, rst_off);
    int   s, n, c, e, tt, endc, a, rs, tend, toe, xlow;
    exp_t ex;
    s    = cyc;
    n    = s + 3 + p;
    c    = n + 1 + d;
    e    = c + l;
    toe  = TMO_EN ? to : 0;
    tt   = s + 3 + toe - 1;
    endc = (toe > 0 && tt < n) ? tt : e;
    if (abort == 1)      a = int'($urandom_range(endc, s + 3));
    else if (abort == 2) a = n;
    else                 a = endc + 3 + q;
    rs   = (rst_off >= 0) ? n + 1 + rst_off : -1;
    xlow = a - 2;
    if (rs >= 0 && rs < xlow) xlow = rs;
    tend = ((rs > a) ? rs : a) + 4;

    m_s = s; m_n = n; m_c = c; m_e = e; m_tt = tt; m_a = a; m_rs = rs; m_w = w;
    m_hit  = (toe > 0) && (tt < n) && (tt < a);
    m_acc  = (n < a) && !((toe > 0) && (tt < n));
    m_ptmo = prev_tmo;
    if (m_acc && n + w + 1 > tend) tend = n + w + 1;

    for (int t = s; t <= tend; t++) sb.push_back(model_at(t));

    bus.I_delay      = DW'(d);
    bus.I_trig_width = TW'(w);
    bus.I_timeout    = TOW'(to);
    for (int t = s; t <= tend; t++) begin
      ex = model_at(t);
      reset_i     = (t == rs);
      bus.I_arm   = (t < xlow);
      if (t == n) begin
        bus.I_pattern_match = (kind & 1) != 0;
        bus.I_sw_trigger    = (kind & 2) != 0;
      end else begin
        bus.I_pattern_match = (ex.st != 3'd1) && ($urandom_range(3, 0) == 0);
        bus.I_sw_trigger    = (ex.st != 3'd1) && ($urandom_range(5, 0) == 0);
      end
      if (m_acc && t > c && t < e)   bus.I_capturing = 1'b1;
      else if (m_acc && t == e)      bus.I_capturing = 1'b0;
      else if (m_acc && t == c)      bus.I_capturing = (l % 2 == 0);
      else                           bus.I_capturing = $urandom_range(1, 0) == 1;
      @(posedge fe_clk); #1;
    end
    reset_i  = 1'b0;
    prev_tmo = m_hit && (rs < 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, w, l, p, k, ab, q, to, ro;
    bus.I_arm = 1'b0; bus.I_pattern_match = 1'b0; bus.I_sw_trigger = 1'b0;
    bus.I_delay = '0; bus.I_trig_width = '0; bus.I_timeout = '0; bus.I_capturing = 1'b0;
    for (int t = 1; t <= 2; t++) sb.push_back('{cyc: t, st: 3'd0, cap: 1'b0, trig: 1'b0,
                                              armed: 1'b0, done: 1'b0, tmo: 1'b0});
    repeat (3) @(posedge fe_clk);
    #1;
    reset_i = 1'b0;

    do_run(0, 4, 10, 2, 1, 0, 1, 0, -1);    // zero delay, 4-cycle pulse
    do_run(5, 2, 3, 1, 2, 0, 0, 0, -1);     // sw trigger, 5-cycle delay
    do_run(3, 6, 4, 2, 1, 2, 0, 0, -1);     // arm lost on the trigger cycle
    do_run(2, 3, 5, 0, 3, 0, 3, 0, -1);     // both triggers, ignored first capturing=0
    do_run(63, 15, 2, 0, 3, 0, 0, 0, -1);   // all-ones delay, max width
    do_run(1, 0, 1, 4, 1, 0, 2, 0, -1);     // no pulse, one-cycle capture
    do_run(2, 15, 3, 1, 1, 0, 0, 0, 1);     // reset mid-pulse
    if (TMO_EN) begin
      do_run(3, 2, 4, 120, 1, 0, 1, 100, -1); // times out 100 cycles after ARMED entry
      do_run(3, 2, 4, 99, 1, 0, 1, 100, -1);  // trigger on the timeout cycle wins
    end

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(5, 0))
        0:       d = 0;
        1:       d = 63;
        default: d = int'($urandom_range(12, 1));
      endcase
      w  = int'($urandom_range(15, 0));
      l  = int'($urandom_range(10, 1));
      p  = int'($urandom_range(7, 0));
      k  = int'($urandom_range(3, 1));
      case ($urandom_range(5, 0))
        0:       ab = 1;
        1:       ab = 2;
        default: ab = 0;
      endcase
      q  = int'($urandom_range(3, 0));
      if (TMO_EN) to = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(10, 1));
      else        to = int'($urandom_range(50, 1));
      ro = -1;
      if ($urandom_range(7, 0) == 0) ro = int'($urandom_range(3, 0));
      do_run(d, w, l, p, k, ab, q, to, ro);
    end

    finishing = 1'b1;
    repeat (2) @(posedge fe_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
